// File: rtl/jtkcpu_ea_seq.sv
// Indexed-addressing fetch sequencer.
// Reads the indexed postbyte and any offset bytes at PC, forms the effective
// address, optionally performs the 16-bit indirect pointer read, then reports
// EA, the advanced PC and any auto-inc/dec register write-back for one cycle.
//
// Ports:
//   clk, rst_n (sync, active-low), cen (clock enable)
//   start, pc_in, x, y, u, s, a, b : request and operands, sampled in IDLE
//   din                            : bus read data, valid the cen cycle after bus_rd
//   bus_addr, bus_rd               : bus read request
//   busy, done, err                : status; done/err pulse for one cen cycle
//   ea, pc_out                     : effective address, PC past operand bytes
//   upd_we, upd_sel, upd_val       : index register write-back (0 X, 1 Y, 2 U, 3 S)
module jtkcpu_ea_seq #(
    parameter int IND_BIG = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        start,
    input  logic [15:0] pc_in,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] u,
    input  logic [15:0] s,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [7:0]  din,
    output logic [15:0] bus_addr,
    output logic        bus_rd,
    output logic        busy,
    output logic        done,
    output logic [15:0] ea,
    output logic [15:0] pc_out,
    output logic        upd_we,
    output logic [1:0]  upd_sel,
    output logic [15:0] upd_val,
    output logic        err
);

    typedef enum logic [3:0] {
        S_IDLE, S_POST, S_RDPB, S_OFS_HI, S_OFS_LO,
        S_CALC, S_IND_HI, S_IND_LO, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  pb_q, pb_d;
    logic [15:0] ofs_q, ofs_d;
    logic [15:0] ea_q, ea_d;
    logic [7:0]  tmp_q, tmp_d;
    logic [15:0] rx_q, rx_d, ry_q, ry_d, ru_q, ru_d, rs_q, rs_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic [1:0]  upd_sel_q, upd_sel_d;
    logic [15:0] upd_val_q, upd_val_d;
    logic        upd_en_q, upd_en_d;
    logic        err_q, err_d;
    logic [15:0] addr_q, addr_d;

    logic        rd;
    logic [15:0] rd_addr;
    logic [15:0] r_val;
    logic [3:0]  mode;
    logic [15:0] calc_ea, calc_upd;
    logic        calc_upd_en, calc_ind, calc_err;
    logic [1:0]  nbytes;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    // Offset bytes that follow a postbyte: n8 modes take one, n16 modes two.
    function automatic logic [1:0] ofs_bytes(input logic [7:0] pb);
        logic [1:0] n;
        n = 2'd0;
        if (!pb[7]) begin
            case (pb[3:0])
                4'h8, 4'hC:        n = 2'd1;
                4'h9, 4'hD, 4'hF:  n = 2'd2;
                default:           n = 2'd0;
            endcase
        end
        return n;
    endfunction

    // Effective address decode from the latched postbyte and offset.
    always_comb begin
        mode        = pb_q[3:0];
        calc_upd    = '0;
        calc_upd_en = 1'b0;
        calc_ind    = 1'b0;
        calc_err    = 1'b0;
        calc_ea     = '0;
        case (pb_q[6:5])
            2'd0:    r_val = rx_q;
            2'd1:    r_val = ry_q;
            2'd2:    r_val = ru_q;
            default: r_val = rs_q;
        endcase
        if (pb_q[7]) begin
            calc_ea = r_val + {{11{pb_q[4]}}, pb_q[4:0]};
        end else begin
            calc_ind = pb_q[4];
            case (mode)
                4'h0: begin
                    calc_ea = r_val; calc_upd = r_val + 16'd1; calc_upd_en = 1'b1;
                    calc_err = pb_q[4];
                end
                4'h1: begin
                    calc_ea = r_val; calc_upd = r_val + 16'd2; calc_upd_en = 1'b1;
                end
                4'h2: begin
                    calc_ea = r_val - 16'd1; calc_upd = calc_ea; calc_upd_en = 1'b1;
                    calc_err = pb_q[4];
                end
                4'h3: begin
                    calc_ea = r_val - 16'd2; calc_upd = calc_ea; calc_upd_en = 1'b1;
                end
                4'h4: calc_ea = r_val;
                4'h5: calc_ea = r_val + sext8(b_q);
                4'h6: calc_ea = r_val + sext8(a_q);
                4'h8: calc_ea = r_val + sext8(ofs_q[7:0]);
                4'h9: calc_ea = r_val + ofs_q;
                4'hB: calc_ea = r_val + {a_q, b_q};
                4'hC: calc_ea = pc_q + sext8(ofs_q[7:0]);
                4'hD: calc_ea = pc_q + ofs_q;
                4'hF: begin
                    calc_ea  = ofs_q;
                    calc_ind = 1'b1;
                end
                default: calc_err = 1'b1;
            endcase
            if (calc_err) begin
                calc_ea     = '0;
                calc_upd_en = 1'b0;
                calc_ind    = 1'b0;
            end
        end
    end

    // Next-state and bus request. Reads are issued one state ahead of the
    // state that latches din, so RDPB decides the first offset read from din.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pb_d      = pb_q;
        ofs_d     = ofs_q;
        ea_d      = ea_q;
        tmp_d     = tmp_q;
        rx_d      = rx_q;
        ry_d      = ry_q;
        ru_d      = ru_q;
        rs_d      = rs_q;
        a_d       = a_q;
        b_d       = b_q;
        upd_sel_d = upd_sel_q;
        upd_val_d = upd_val_q;
        upd_en_d  = upd_en_q;
        err_d     = err_q;
        rd        = 1'b0;
        rd_addr   = '0;
        nbytes    = ofs_bytes(din);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d     = pc_in;
                    rx_d     = x;
                    ry_d     = y;
                    ru_d     = u;
                    rs_d     = s;
                    a_d      = a;
                    b_d      = b;
                    upd_en_d = 1'b0;
                    err_d    = 1'b0;
                    state_d  = S_POST;
                end
            end
            S_POST: begin
                rd      = 1'b1;
                rd_addr = pc_q;
                state_d = S_RDPB;
            end
            S_RDPB: begin
                pb_d  = din;
                pc_d  = pc_q + 16'd1;
                ofs_d = '0;
                if (nbytes != 2'd0) begin
                    rd      = 1'b1;
                    rd_addr = pc_q + 16'd1;
                end
                case (nbytes)
                    2'd2:    state_d = S_OFS_HI;
                    2'd1:    state_d = S_OFS_LO;
                    default: state_d = S_CALC;
                endcase
            end
            S_OFS_HI: begin
                ofs_d   = {din, 8'h00};
                pc_d    = pc_q + 16'd1;
                rd      = 1'b1;
                rd_addr = pc_q + 16'd1;
                state_d = S_OFS_LO;
            end
            S_OFS_LO: begin
                ofs_d   = {ofs_q[15:8], din};
                pc_d    = pc_q + 16'd1;
                state_d = S_CALC;
            end
            S_CALC: begin
                ea_d      = calc_ea;
                upd_sel_d = pb_q[6:5];
                upd_val_d = calc_upd;
                upd_en_d  = calc_upd_en;
                err_d     = calc_err;
                if (calc_ind) begin
                    rd      = 1'b1;
                    rd_addr = calc_ea;
                    state_d = S_IND_HI;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_IND_HI: begin
                tmp_d   = din;
                rd      = 1'b1;
                rd_addr = ea_q + 16'd1;
                state_d = S_IND_LO;
            end
            S_IND_LO: begin
                ea_d    = (IND_BIG != 0) ? {tmp_q, din} : {din, tmp_q};
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        bus_addr = rd ? rd_addr : addr_q;
        addr_d   = bus_addr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            pb_q      <= '0;
            ofs_q     <= '0;
            ea_q      <= '0;
            tmp_q     <= '0;
            rx_q      <= '0;
            ry_q      <= '0;
            ru_q      <= '0;
            rs_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            upd_sel_q <= '0;
            upd_val_q <= '0;
            upd_en_q  <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
        end else if (cen) begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pb_q      <= pb_d;
            ofs_q     <= ofs_d;
            ea_q      <= ea_d;
            tmp_q     <= tmp_d;
            rx_q      <= rx_d;
            ry_q      <= ry_d;
            ru_q      <= ru_d;
            rs_q      <= rs_d;
            a_q       <= a_d;
            b_q       <= b_d;
            upd_sel_q <= upd_sel_d;
            upd_val_q <= upd_val_d;
            upd_en_q  <= upd_en_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
        end
    end

    assign bus_rd  = rd;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign ea      = ea_q;
    assign pc_out  = pc_q;
    assign upd_we  = done & upd_en_q;
    assign upd_sel = upd_sel_q;
    assign upd_val = upd_val_q;
    assign err     = done & err_q;

endmodule

// File: tb/tb_jtkcpu_ea_seq.sv
// Scoreboard bench for jtkcpu_ea_seq: stimulus pushes expected results,
// a negedge monitor pops and compares them whenever done is presented.
module tb_jtkcpu_ea_seq;

    logic        clk, rst_n, cen, start;
    logic [15:0] pc_in, x, y, u, s;
    logic [7:0]  a, b, din;
    logic [15:0] bus_addr, ea, pc_out, upd_val;
    logic        bus_rd, busy, done, upd_we, err;
    logic [1:0]  upd_sel;

    jtkcpu_ea_seq #(.IND_BIG(1)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .pc_in(pc_in),
        .x(x), .y(y), .u(u), .s(s), .a(a), .b(b), .din(din),
        .bus_addr(bus_addr), .bus_rd(bus_rd), .busy(busy), .done(done),
        .ea(ea), .pc_out(pc_out), .upd_we(upd_we), .upd_sel(upd_sel),
        .upd_val(upd_val), .err(err)
    );

    typedef struct {
        logic [15:0] ea;
        logic [15:0] pc;
        logic        we;
        logic [1:0]  sel;
        logic [15:0] val;
        logic        er;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mem [0:65535];
    int          nchk = 0;
    int          nerr = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cnt = 0;
    int          cen_mode = 0;  // 0 always on, 1 random, 2 held off

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (cen_mode == 1)      cen = 1'($urandom_range(0, 1));
        else                    cen = (cen_mode == 0);
    end

    always @(posedge clk) begin
        if (cen && bus_rd) din <= mem[bus_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && start && cen && !busy) start_cyc = cyc;
        if (rst_n && cen && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_done: got done=1 expected no done (ea=%h)", ea);
            end else begin
                e = sb.pop_front();
                chk("ea", 32'(ea), 32'(e.ea));
                chk("pc_out", 32'(pc_out), 32'(e.pc));
                chk("upd_we", 32'(upd_we), 32'(e.we));
                chk("err", 32'(err), 32'(e.er));
                if (e.we) begin
                    chk("upd_sel", 32'(upd_sel), 32'(e.sel));
                    chk("upd_val", 32'(upd_val), 32'(e.val));
                end
                chk("latency", 32'(cyc - start_cyc), 32'(e.lat));
            end
        end
        if (cen) cyc++;
    end

    task automatic run(input logic [15:0] pc, input logic [7:0] pb,
                       input logic [7:0] o1, input logic [7:0] o2,
                       input logic [15:0] e_ea, input logic [15:0] e_pc,
                       input logic e_we, input logic [1:0] e_sel,
                       input logic [15:0] e_val, input logic e_er,
                       input int e_lat, input bit hold);
        exp_t e;
        int   ok;
        mem[pc]          = pb;
        mem[pc + 16'd1]  = o1;
        mem[pc + 16'd2]  = o2;
        e.ea = e_ea; e.pc = e_pc; e.we = e_we; e.sel = e_sel;
        e.val = e_val; e.er = e_er; e.lat = e_lat;
        sb.push_back(e);
        pc_in = pc;
        start = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cen && !busy) begin ok = 1; break; end
        end
        if (ok == 0) chk("start_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #2;
        if (!hold) start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #2;
        end
        start = 1'b0;
        if (sb.size() != 0) begin
            chk("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(posedge clk); #2;
    endtask

    initial begin
        rst_n = 1'b0; cen = 1'b1; start = 1'b0;
        pc_in = '0; x = '0; y = '0; u = '0; s = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bus_rd", 32'(bus_rd), 32'd0);
        chk("rst_ea", 32'(ea), 32'd0);
        chk("rst_pc_out", 32'(pc_out), 32'd0);
        chk("rst_bus_addr", 32'(bus_addr), 32'd0);
        chk("rst_upd", 32'({upd_we, upd_sel, upd_val, err}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        x = 16'h1000;
        run(16'h0200, 8'h9F, 8'h00, 8'h00, 16'h0FFF, 16'h0201, 1'b0, 2'd0, 16'h0000, 1'b0, 4, 1'b0);
        y = 16'h2000;
        run(16'h0300, 8'h21, 8'h00, 8'h00, 16'h2000, 16'h0301, 1'b1, 2'd1, 16'h2002, 1'b0, 4, 1'b0);
        run(16'h0100, 8'h0D, 8'h12, 8'h34, 16'h1337, 16'h0103, 1'b0, 2'd0, 16'h0000, 1'b0, 6, 1'b0);
        mem[16'h4000] = 8'hAB; mem[16'h4001] = 8'hCD;
        run(16'h0400, 8'h1F, 8'h40, 8'h00, 16'hABCD, 16'h0403, 1'b0, 2'd0, 16'h0000, 1'b0, 8, 1'b1);
        s = 16'hFFFF;
        run(16'h0500, 8'h60, 8'h00, 8'h00, 16'hFFFF, 16'h0501, 1'b1, 2'd3, 16'h0000, 1'b0, 4, 1'b0);
        run(16'h0600, 8'h07, 8'h00, 8'h00, 16'h0000, 16'h0601, 1'b0, 2'd0, 16'h0000, 1'b1, 4, 1'b0);
        u = 16'h1234;
        run(16'h0A00, 8'h48, 8'h80, 8'h00, 16'h11B4, 16'h0A02, 1'b0, 2'd0, 16'h0000, 1'b0, 5, 1'b0);
        x = 16'h0010; b = 8'hF0;
        run(16'h0A10, 8'h05, 8'h00, 8'h00, 16'h0000, 16'h0A11, 1'b0, 2'd0, 16'h0000, 1'b0, 4, 1'b0);
        x = 16'h8000; a = 8'h12; b = 8'h34;
        run(16'h0A20, 8'h0B, 8'h00, 8'h00, 16'h9234, 16'h0A21, 1'b0, 2'd0, 16'h0000, 1'b0, 4, 1'b0);
        x = 16'h5000;
        mem[16'h4FFE] = 8'h12; mem[16'h4FFF] = 8'h34;
        run(16'h0800, 8'h13, 8'h00, 8'h00, 16'h1234, 16'h0801, 1'b1, 2'd0, 16'h4FFE, 1'b0, 6, 1'b0);
        run(16'h0810, 8'h12, 8'h00, 8'h00, 16'h0000, 16'h0811, 1'b0, 2'd0, 16'h0000, 1'b1, 4, 1'b0);
        mem[16'hFFFF] = 8'hBE; mem[16'h0000] = 8'hEF;
        run(16'h0900, 8'h1F, 8'hFF, 8'hFF, 16'hBEEF, 16'h0903, 1'b0, 2'd0, 16'h0000, 1'b0, 8, 1'b0);
        run(16'h0B00, 8'h0C, 8'hFE, 8'h00, 16'h0B00, 16'h0B02, 1'b0, 2'd0, 16'h0000, 1'b0, 5, 1'b0);
        y = 16'h0100; a = 8'h80;
        run(16'h0B10, 8'h26, 8'h00, 8'h00, 16'h0080, 16'h0B11, 1'b0, 2'd0, 16'h0000, 1'b0, 4, 1'b0);
        s = 16'hABCD;
        run(16'h0B20, 8'h64, 8'h00, 8'h00, 16'hABCD, 16'h0B21, 1'b0, 2'd0, 16'h0000, 1'b0, 4, 1'b0);
        u = 16'h0000;
        run(16'h0B30, 8'h42, 8'h00, 8'h00, 16'hFFFF, 16'h0B31, 1'b1, 2'd2, 16'hFFFF, 1'b0, 4, 1'b1);

        // Random clock-enable stalls: values and cen-cycle latency unchanged.
        cen_mode = 1;
        run(16'h0C00, 8'h0D, 8'h12, 8'h34, 16'h1E37, 16'h0C03, 1'b0, 2'd0, 16'h0000, 1'b0, 6, 1'b0);
        run(16'h0D00, 8'h1F, 8'h40, 8'h00, 16'hABCD, 16'h0D03, 1'b0, 2'd0, 16'h0000, 1'b0, 8, 1'b1);
        y = 16'h2000;
        run(16'h0D10, 8'h21, 8'h00, 8'h00, 16'h2000, 16'h0D11, 1'b1, 2'd1, 16'h2002, 1'b0, 4, 1'b0);
        cen_mode = 0;
        @(posedge clk); #2;

        // Abort in OFS_LO with reset applied while cen is low.
        mem[16'h0E00] = 8'h08; mem[16'h0E01] = 8'h05;
        pc_in = 16'h0E00;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        chk("abort_busy_post", 32'(busy), 32'd1);
        @(posedge clk); #2;
        cen_mode = 2;
        @(posedge clk); #2;
        chk("abort_pc_ofs_lo", 32'(pc_out), 32'h0E01);
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        cen_mode = 0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ea", 32'(ea), 32'd0);
        chk("abort_pc_out", 32'(pc_out), 32'd0);
        begin
            int dc;
            dc = done_cnt;
            repeat (10) @(posedge clk);
            #2;
            chk("abort_no_done", 32'(done_cnt), 32'(dc));
            chk("abort_idle_busy", 32'(busy), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
